// File: rtl/regfile_wb_scheduler.sv
// Write-back scheduler and scoreboard for the 32x32 register file.
// Arbitrates the single write port between producer A and producer B
// (round-robin) and tracks which destination registers still have results
// outstanding, so the issue stage can stall on RAW/WAW hazards.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   issue_valid/rd/rs1/rs2          instruction being issued this cycle
//   issue_stall                     combinational hold request to issue
//   a_valid/a_rd/a_data, a_ready    producer A handshake (ready is combinational)
//   b_valid/b_rd/b_data, b_ready    producer B handshake (ready is combinational)
//   RegWrite/rd/WriteData           registered register-file write port
//   busy                            scoreboard, bit i = register i outstanding
//   prio                            round-robin pointer (0 = A preferred)
//   err                             sticky: write arrived for a non-busy register
module regfile_wb_scheduler #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     issue_valid,
  input  logic [ADDR_W-1:0]        issue_rd,
  input  logic [ADDR_W-1:0]        issue_rs1,
  input  logic [ADDR_W-1:0]        issue_rs2,
  output logic                     issue_stall,
  input  logic                     a_valid,
  input  logic [ADDR_W-1:0]        a_rd,
  input  logic [DATA_W-1:0]        a_data,
  output logic                     a_ready,
  input  logic                     b_valid,
  input  logic [ADDR_W-1:0]        b_rd,
  input  logic [DATA_W-1:0]        b_data,
  output logic                     b_ready,
  output logic                     RegWrite,
  output logic [ADDR_W-1:0]        rd,
  output logic [DATA_W-1:0]        WriteData,
  output logic [(2**ADDR_W)-1:0]   busy,
  output logic                     prio,
  output logic                     err
);

  localparam int unsigned NREG = 2 ** ADDR_W;

  logic              grant_a;
  logic              grant_b;
  logic              xfer;
  logic [ADDR_W-1:0] xfer_rd;
  logic [DATA_W-1:0] xfer_data;
  logic [NREG-1:0]   busy_nxt;
  logic              err_hit;

  // Round-robin grant: a lone requester always wins, prio breaks ties.
  always_comb begin
    grant_a   = a_valid && (!b_valid || !prio);
    grant_b   = b_valid && !grant_a;
    xfer      = grant_a || grant_b;
    xfer_rd   = grant_a ? a_rd : b_rd;
    xfer_data = grant_a ? a_data : b_data;
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;

  // Hazard check looks only at the scoreboard; there is no producer bypass.
  assign issue_stall = issue_valid &&
                       (busy[issue_rs1] || busy[issue_rs2] || busy[issue_rd]);

  // Scoreboard update: clear on committed write, then set on issue (set wins).
  always_comb begin
    busy_nxt = busy;
    if (RegWrite && (rd != '0)) begin
      busy_nxt[rd] = 1'b0;
    end
    if (issue_valid && !issue_stall && (issue_rd != '0)) begin
      busy_nxt[issue_rd] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  // A write is only legitimate if its register is still outstanding after
  // this edge's clear; an issue of the same register on the same edge
  // counts as outstanding, so back-to-back reissue/writeback is not an error.
  assign err_hit = xfer && (xfer_rd != '0) && !busy_nxt[xfer_rd];

  // Output register, scoreboard, round-robin pointer and sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RegWrite  <= 1'b0;
      rd        <= '0;
      WriteData <= '0;
      busy      <= '0;
      prio      <= 1'b0;
      err       <= 1'b0;
    end else begin
      busy <= busy_nxt;
      err  <= err || err_hit;
      if (xfer) begin
        RegWrite  <= (xfer_rd != '0);
        rd        <= xfer_rd;
        WriteData <= xfer_data;
        prio      <= grant_a;
      end else begin
        RegWrite <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Bench for regfile_wb_scheduler: a directed vector table with hand-derived
// expectations, hand-written asynchronous reset sequences, then randomized
// traffic checked against a cycle-level reference model of the scheduler.
module tb_regfile_wb_scheduler;

  logic        clk;
  logic        rst_n;
  logic        issue_valid;
  logic [4:0]  issue_rd, issue_rs1, issue_rs2;
  logic        issue_stall;
  logic        a_valid, b_valid;
  logic [4:0]  a_rd, b_rd;
  logic [31:0] a_data, b_data;
  logic        a_ready, b_ready;
  logic        RegWrite;
  logic [4:0]  rd;
  logic [31:0] WriteData;
  logic [31:0] busy;
  logic        prio;
  logic        err;

  int checks;
  int failures;

  regfile_wb_scheduler #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_stall(issue_stall),
    .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
    .RegWrite(RegWrite), .rd(rd), .WriteData(WriteData),
    .busy(busy), .prio(prio), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [4:0]  ird, irs1;
    logic        av;
    logic [4:0]  ard;
    logic [31:0] ad;
    logic        bv;
    logic [4:0]  brd;
    logic [31:0] bd;
    logic        e_stall, e_ar, e_br, e_rw;
    logic [4:0]  e_rd;
    logic [31:0] e_wd, e_busy;
    logic        e_prio, e_err;
  } vec_t;

  vec_t vt[21];

  function automatic vec_t v(input int iv, ird, irs1, av, ard, ad, bv, brd, bd,
                             e_stall, e_ar, e_br, e_rw, e_rd, e_wd, e_busy,
                             e_prio, e_err);
    vec_t r;
    r.iv = 1'(iv); r.ird = 5'(ird); r.irs1 = 5'(irs1);
    r.av = 1'(av); r.ard = 5'(ard); r.ad = 32'(ad);
    r.bv = 1'(bv); r.brd = 5'(brd); r.bd = 32'(bd);
    r.e_stall = 1'(e_stall); r.e_ar = 1'(e_ar); r.e_br = 1'(e_br);
    r.e_rw = 1'(e_rw); r.e_rd = 5'(e_rd); r.e_wd = 32'(e_wd);
    r.e_busy = 32'(e_busy); r.e_prio = 1'(e_prio); r.e_err = 1'(e_err);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic e_stall, e_ar, e_br, e_rw,
                            input logic [4:0] e_rd, input logic [31:0] e_wd, e_busy,
                            input logic e_prio, e_err);
    chk({tag, ".issue_stall"}, 32'(issue_stall), 32'(e_stall));
    chk({tag, ".a_ready"},     32'(a_ready),     32'(e_ar));
    chk({tag, ".b_ready"},     32'(b_ready),     32'(e_br));
    chk({tag, ".RegWrite"},    32'(RegWrite),    32'(e_rw));
    chk({tag, ".rd"},          32'(rd),          32'(e_rd));
    chk({tag, ".WriteData"},   WriteData,        e_wd);
    chk({tag, ".busy"},        busy,             e_busy);
    chk({tag, ".prio"},        32'(prio),        32'(e_prio));
    chk({tag, ".err"},         32'(err),         32'(e_err));
  endtask

  task automatic drive_idle();
    issue_valid = 1'b0; issue_rd = '0; issue_rs1 = '0; issue_rs2 = '0;
    a_valid = 1'b0; a_rd = '0; a_data = '0;
    b_valid = 1'b0; b_rd = '0; b_data = '0;
  endtask

  // Assert reset right now (mid-cycle) and check registered state clears
  // without any clock edge, then release just after the next rising edge.
  task automatic assert_reset_now(input string tag);
    rst_n = 1'b0;
    #1;
    chk({tag, ".RegWrite"},  32'(RegWrite),  32'd0);
    chk({tag, ".rd"},        32'(rd),        32'd0);
    chk({tag, ".WriteData"}, WriteData,      32'd0);
    chk({tag, ".busy"},      busy,           32'd0);
    chk({tag, ".prio"},      32'(prio),      32'd0);
    chk({tag, ".err"},       32'(err),       32'd0);
    drive_idle();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic async_reset_check(input string tag);
    @(negedge clk); #2;
    assert_reset_now(tag);
  endtask

  // Reference model state
  bit        m_busy[32];
  bit        m_prio, m_err, m_rw;
  bit [4:0]  m_rd;
  bit [31:0] m_wd;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    m_prio = 1'b0; m_err = 1'b0; m_rw = 1'b0; m_rd = '0; m_wd = '0;
  endtask

  function automatic logic [31:0] model_busy_vec();
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = m_busy[i];
    return r;
  endfunction

  // Mostly target registers that are really outstanding, sometimes anything.
  function automatic logic [4:0] pick_rd();
    int q[$];
    for (int i = 1; i < 32; i++) if (m_busy[i]) q.push_back(i);
    if (q.size() != 0 && $urandom_range(0, 4) != 0)
      return 5'(q[$urandom_range(0, q.size() - 1)]);
    return 5'($urandom_range(0, 31));
  endfunction

  bit        pa_v, pb_v;
  logic [4:0]  pa_rd, pb_rd;
  logic [31:0] pa_d, pb_d;

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    drive_idle();

    // Round-robin, x0, RAW stall, set/clear collision, error flag.
    vt[0]  = v(1,1,0, 0,0,0,            0,0,0,       0,0,0, 0,0,0,            'h0,  0,0);
    vt[1]  = v(1,2,0, 0,0,0,            0,0,0,       0,0,0, 0,0,0,            'h2,  0,0);
    vt[2]  = v(0,0,0, 1,1,'h111,        1,2,'h222,   0,1,0, 0,0,0,            'h6,  0,0);
    vt[3]  = v(0,0,0, 1,1,'h111,        1,2,'h222,   0,0,1, 1,1,'h111,        'h6,  1,0);
    vt[4]  = v(1,1,0, 1,1,'h111,        1,2,'h222,   0,1,0, 1,2,'h222,        'h4,  0,0);
    vt[5]  = v(1,2,0, 1,1,'h111,        1,2,'h222,   0,0,1, 1,1,'h111,        'h2,  1,0);
    vt[6]  = v(1,0,0, 0,0,0,            0,0,0,       0,0,0, 1,2,'h222,        'h4,  0,0);
    vt[7]  = v(0,0,0, 0,0,0,            1,0,'h1234,  0,0,1, 0,2,'h222,        'h0,  0,0);
    vt[8]  = v(0,0,0, 0,0,0,            0,0,0,       0,0,0, 0,0,'h1234,       'h0,  0,0);
    vt[9]  = v(1,5,0, 0,0,0,            0,0,0,       0,0,0, 0,0,'h1234,       'h0,  0,0);
    vt[10] = v(1,0,5, 1,5,'hDEADBEEF,   0,0,0,       1,1,0, 0,0,'h1234,       'h20, 0,0);
    vt[11] = v(1,0,5, 0,0,0,            0,0,0,       1,0,0, 1,5,'hDEADBEEF,   'h20, 1,0);
    vt[12] = v(1,0,5, 0,0,0,            0,0,0,       0,0,0, 0,5,'hDEADBEEF,   'h0,  1,0);
    vt[13] = v(1,9,0, 0,0,0,            0,0,0,       0,0,0, 0,5,'hDEADBEEF,   'h0,  1,0);
    vt[14] = v(0,0,0, 1,9,'h99,         0,0,0,       0,1,0, 0,5,'hDEADBEEF,   'h200,1,0);
    vt[15] = v(1,9,0, 0,0,0,            0,0,0,       1,0,0, 1,9,'h99,         'h200,1,0);
    vt[16] = v(1,9,0, 0,0,0,            0,0,0,       0,0,0, 0,9,'h99,         'h0,  1,0);
    vt[17] = v(0,0,0, 0,0,0,            0,0,0,       0,0,0, 0,9,'h99,         'h200,1,0);
    vt[18] = v(0,0,0, 1,7,'h77,         0,0,0,       0,1,0, 0,9,'h99,         'h200,1,0);
    vt[19] = v(0,0,0, 0,0,0,            0,0,0,       0,0,0, 1,7,'h77,         'h200,1,1);
    vt[20] = v(0,0,0, 0,0,0,            0,0,0,       0,0,0, 0,7,'h77,         'h200,1,1);

    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      issue_valid = vt[i].iv; issue_rd = vt[i].ird; issue_rs1 = vt[i].irs1; issue_rs2 = '0;
      a_valid = vt[i].av; a_rd = vt[i].ard; a_data = vt[i].ad;
      b_valid = vt[i].bv; b_rd = vt[i].brd; b_data = vt[i].bd;
      @(negedge clk);
      check_outs($sformatf("vec%0d", i), vt[i].e_stall, vt[i].e_ar, vt[i].e_br,
                 vt[i].e_rw, vt[i].e_rd, vt[i].e_wd, vt[i].e_busy,
                 vt[i].e_prio, vt[i].e_err);
      @(posedge clk); #1;
    end

    // Sticky err, prio and busy all drop on an asynchronous reset.
    drive_idle();
    async_reset_check("rst_err");

    // Reset mid-cycle while busy=0x4 and a write is on the port.
    issue_valid = 1'b1; issue_rd = 5'd2;
    @(posedge clk); #1;
    drive_idle();
    a_valid = 1'b1; a_rd = 5'd2; a_data = 32'hABCD_0002;
    @(negedge clk);
    chk("rst_setup.a_ready", 32'(a_ready), 32'd1);
    chk("rst_setup.busy", busy, 32'h4);
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    chk("rst_pre.RegWrite", 32'(RegWrite), 32'd1);
    chk("rst_pre.busy", busy, 32'h4);
    #2;
    assert_reset_now("rst_mid");

    // Randomized traffic against the reference model.
    model_reset();
    pa_v = 1'b0; pb_v = 1'b0;
    pa_rd = '0; pb_rd = '0; pa_d = '0; pb_d = '0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 600 == 599) begin
        drive_idle();
        pa_v = 1'b0; pb_v = 1'b0;
        async_reset_check($sformatf("rnd_rst%0d", c));
        model_reset();
      end else begin
        bit ga, gb, stall, iv;
        bit nb[32];
        logic [4:0] ird, irs1, irs2, wr;
        logic [31:0] wd;
        if (!pa_v && $urandom_range(0, 2) == 0) begin
          pa_v = 1'b1; pa_rd = pick_rd(); pa_d = $urandom();
        end
        if (!pb_v && $urandom_range(0, 2) == 0) begin
          pb_v = 1'b1; pb_rd = pick_rd(); pb_d = $urandom();
        end
        iv   = 1'($urandom_range(0, 1));
        ird  = 5'($urandom_range(0, 7));
        irs1 = 5'($urandom_range(0, 7));
        irs2 = 5'($urandom_range(0, 7));
        issue_valid = iv; issue_rd = ird; issue_rs1 = irs1; issue_rs2 = irs2;
        a_valid = pa_v; a_rd = pa_rd; a_data = pa_d;
        b_valid = pb_v; b_rd = pb_rd; b_data = pb_d;

        ga = pa_v && (!pb_v || !m_prio);
        gb = pb_v && !ga;
        stall = iv && (m_busy[irs1] || m_busy[irs2] || m_busy[ird]);

        @(negedge clk);
        check_outs($sformatf("rnd%0d", c), stall, ga, gb, m_rw, m_rd, m_wd,
                   model_busy_vec(), m_prio, m_err);

        // Next state from the scheduling rules.
        nb = m_busy;
        if (m_rw && m_rd != 0) nb[m_rd] = 1'b0;
        if (iv && !stall && ird != 0) nb[ird] = 1'b1;
        if (ga || gb) begin
          wr = ga ? pa_rd : pb_rd;
          wd = ga ? pa_d : pb_d;
          if (wr != 0 && !nb[wr]) m_err = 1'b1;
          m_rw = (wr != 0);
          m_rd = wr;
          m_wd = wd;
          m_prio = ga;
        end else begin
          m_rw = 1'b0;
        end
        m_busy = nb;
        if (ga) pa_v = 1'b0;
        if (gb) pb_v = 1'b0;
        @(posedge clk); #1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
